// File: rtl/ram_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_scan_ctrl_if
// Description : Bus bundle between the board top level and ram_scan_ctrl.
//               master = user/board side, slave = the RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_scan_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  write_key;
   logic                  scan_en;
   logic                  busy;
   logic                  write_done;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (
      output wr_addr, wr_data, write_key, scan_en,
      input  busy, write_done, rd_addr, rd_data
   );

   modport slave (
      input  wr_addr, wr_data, write_key, scan_en,
      output busy, write_done, rd_addr, rd_data
   );
endinterface
`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_scan_ctrl
// Description : On-chip RAM with a self-clearing sequence after reset, a
//               key-edge write port and a manual / auto-scan read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_scan_ctrl #(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 4,
   parameter int SCAN_PERIOD = 50_000_000
) (
   input  logic           clk,
   input  logic           reset,
   ram_scan_ctrl_if.slave bus
);

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;
   localparam int c_CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(SCAN_PERIOD - 1);
   localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = '1;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_clr_ptr;
   logic                  r_key_prev;
   logic                  r_write_done;
   logic [c_CNT_W-1:0]    r_scan_cnt;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

   logic                  w_press;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_waddr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [ADDR_WIDTH-1:0] w_rd_addr_next;
   logic [c_CNT_W-1:0]    w_cnt_next;
   logic                  w_wr_hit;

   // State register: reset always restarts the clear sequence.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_CLEAR;
      else       r_state <= w_state_next;
   end

   // Next state, RAM write port selection and next read address.
   always_comb begin
      w_state_next   = r_state;
      w_press        = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_waddr    = bus.wr_addr;
      w_mem_wdata    = bus.wr_data;
      w_rd_addr_next = '0;
      w_cnt_next     = '0;
      case (r_state)
         S_CLEAR: begin
            // Zero one word per cycle; user writes and reads are locked out.
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_ptr;
            w_mem_wdata = '0;
            if (r_clr_ptr == c_ADDR_LAST) w_state_next = S_RUN;
         end
         S_RUN: begin
            w_press  = bus.write_key & ~r_key_prev;
            w_mem_we = w_press;
            if (bus.scan_en) begin
               if (r_scan_cnt == c_CNT_LAST) begin
                  w_rd_addr_next = r_rd_addr + 1'b1;
                  w_cnt_next     = '0;
               end else begin
                  w_rd_addr_next = r_rd_addr;
                  w_cnt_next     = r_scan_cnt + 1'b1;
               end
            end else begin
               w_rd_addr_next = bus.wr_addr;
            end
         end
         default: w_state_next = S_CLEAR;
      endcase
   end

   // A press landing on the address being read bypasses the array.
   assign w_wr_hit = w_press && (bus.wr_addr == w_rd_addr_next);

   // Clear pointer walks every address once per clear sequence.
   always_ff @(posedge clk) begin
      if (reset)                   r_clr_ptr <= '0;
      else if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
   end

   // Key edge detector; preloaded high so a key held through reset is ignored.
   always_ff @(posedge clk) begin
      if (reset) r_key_prev <= 1'b1;
      else       r_key_prev <= bus.write_key;
   end

   // write_done pulses the cycle after a performed write.
   always_ff @(posedge clk) begin
      if (reset) r_write_done <= 1'b0;
      else       r_write_done <= w_press;
   end

   // Scan rate divider and read address register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_rd_addr  <= '0;
      end else begin
         r_scan_cnt <= w_cnt_next;
         r_rd_addr  <= w_rd_addr_next;
      end
   end

   // Read data tracks the address loaded on the same edge, write-first.
   always_ff @(posedge clk) begin
      if (reset || (r_state == S_CLEAR)) r_rd_data <= '0;
      else if (w_wr_hit)                 r_rd_data <= bus.wr_data;
      else                               r_rd_data <= r_mem[w_rd_addr_next];
   end

   // Single write port shared by the clear sequence and key presses.
   always_ff @(posedge clk) begin
      if (w_mem_we && !reset) r_mem[w_mem_waddr] <= w_mem_wdata;
   end

   assign bus.busy       = (r_state == S_CLEAR);
   assign bus.write_done = r_write_done;
   assign bus.rd_addr    = r_rd_addr;
   assign bus.rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_scan_ctrl
// Description : Scoreboard bench for ram_scan_ctrl: the stimulus process
//               queues expected outputs from a behavioural model, a monitor
//               pops and compares them after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_scan_ctrl;

   localparam int AW    = 5;
   localparam int DW    = 4;
   localparam int P     = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ram_scan_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_scan_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .SCAN_PERIOD(P)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      bit          busy;
      bit          wd;
      int unsigned addr;
      int unsigned data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: clearing is "fewer than DEPTH cycles since reset",
   // scanning is "base + elapsed/P", memory is a plain array.
   int unsigned m_mem[DEPTH];
   int          m_since_rst = 0;
   bit          m_key_prev  = 1'b1;
   int          m_scan_n    = 0;
   int unsigned m_scan_base = 0;
   int unsigned m_rd_addr   = 0;
   int unsigned m_rd_data   = 0;
   bit          m_wd        = 1'b0;

   task automatic model_step(input bit rst, input int unsigned addr, input int unsigned data,
                             input bit key, input bit scan, output exp_t e);
      int unsigned nxt;
      bit          press;
      if (rst) begin
         m_since_rst = 0; m_key_prev = 1'b1; m_scan_n = 0;
         m_rd_addr = 0; m_rd_data = 0; m_wd = 1'b0;
         e.busy = 1'b1;
      end else if (m_since_rst < DEPTH) begin
         m_since_rst++;
         if (m_since_rst == DEPTH) foreach (m_mem[i]) m_mem[i] = 0;
         m_key_prev = key; m_scan_n = 0;
         m_rd_addr = 0; m_rd_data = 0; m_wd = 1'b0;
         e.busy = (m_since_rst < DEPTH);
      end else begin
         press = key && !m_key_prev;
         if (scan) begin
            if (m_scan_n == 0) m_scan_base = m_rd_addr;
            m_scan_n++;
            nxt = (m_scan_base + m_scan_n / P) % DEPTH;
         end else begin
            m_scan_n = 0;
            nxt = addr;
         end
         if (press) m_mem[addr] = data;
         m_rd_addr  = nxt;
         m_rd_data  = m_mem[nxt];
         m_wd       = press;
         m_key_prev = key;
         e.busy     = 1'b0;
      end
      e.wd   = m_wd;
      e.addr = m_rd_addr;
      e.data = m_rd_data;
   endtask

   // Scan address the next edge will show while scanning stays enabled.
   function automatic int unsigned pred_scan_addr();
      int unsigned base;
      base = (m_scan_n == 0) ? m_rd_addr : m_scan_base;
      return (base + (m_scan_n + 1) / P) % DEPTH;
   endfunction

   task automatic drive(input bit rst, input int unsigned addr, input int unsigned data,
                        input bit key, input bit scan);
      exp_t        e;
      int unsigned a;
      int unsigned d;
      a = addr % DEPTH;
      d = data % (1 << DW);
      @(negedge clk);
      reset         = rst;
      bus.wr_addr   = a[AW-1:0];
      bus.wr_data   = d[DW-1:0];
      bus.write_key = key;
      bus.scan_en   = scan;
      model_step(rst, a, d, key, scan, e);
      exp_q.push_back(e);
   endtask

   task automatic press(input int unsigned addr, input int unsigned data);
      drive(1'b0, addr, data, 1'b1, 1'b0);
      drive(1'b0, addr, data, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
   endtask

   // Monitor: one expected record per clock edge, compared just after it.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy",       {31'd0, bus.busy},       {31'd0, e.busy});
            check("write_done", {31'd0, bus.write_done}, {31'd0, e.wd});
            check("rd_addr",    {{(32-AW){1'b0}}, bus.rd_addr}, e.addr);
            check("rd_data",    {{(32-DW){1'b0}}, bus.rd_data}, e.data);
         end
      end
   end

   initial begin : stimulus
      bit key;
      bit scan;
      int wait_cyc;
      reset = 1'b1; bus.wr_addr = '0; bus.wr_data = '0;
      bus.write_key = 1'b0; bus.scan_en = 1'b0;

      // Clear after reset, then manual reads of cleared words.
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) drive(0, $urandom, $urandom, 0, 0);
      drive(0, 'h00, 0, 0, 0); drive(0, 'h00, 0, 0, 0);
      drive(0, 'h15, 0, 0, 0); drive(0, 'h15, 0, 0, 0);
      drive(0, 'h1F, 0, 0, 0); drive(0, 'h1F, 0, 0, 0);

      // One write per press while the key is held.
      for (int i = 0; i < 5; i++) drive(0, 'h0A, 'hA, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 'h0A, 'hA, 0, 0);

      // Key held through reset and clear is not a press.
      drive(1, 'h03, 'hF, 1, 0);
      drive(1, 'h03, 'hF, 1, 0);
      for (int i = 0; i < 36; i++) drive(0, 'h03, 'hF, 1, 0);
      drive(0, 'h03, 'hF, 0, 0);
      drive(0, 'h03, 'hF, 0, 0);
      press('h03, 'hF);
      drive(0, 'h03, 'hF, 0, 0);

      // Scan wrap from 0x1E through 0x1F to 0x00.
      press('h1F, 'h5);
      press('h00, 'h3);
      drive(0, 'h1E, 0, 0, 0);
      drive(0, 'h1E, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 'h1E, 0, 0, 1);

      // Write-first: press the address the scan steps onto on that edge.
      for (int i = 0; i < 24; i++) begin
         key = ((m_scan_n + 1) % P) == 0;
         drive(0, pred_scan_addr(), $urandom, key, 1);
      end
      // Scan off: manual reads resume on the next edge.
      for (int i = 0; i < 4; i++) drive(0, $urandom, 0, 0, 0);

      // Reset in the middle of the clear sequence.
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, $urandom, $urandom, $urandom_range(0, 1), 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) drive(0, $urandom, $urandom, $urandom_range(0, 1), 0);

      // Randomised traffic with occasional scan toggles and resets.
      scan = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) scan = ~scan;
         drive($urandom_range(0, 299) == 0, $urandom, $urandom,
               $urandom_range(0, 2) == 0, scan);
      end

      // Let the monitor drain the scoreboard, bounded.
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
